// File: rtl/mio_pkg.sv
// Shared register map and status bit positions for the MIO I/O window.
package mio_pkg;

  localparam logic [2:0] OFS_SCROLL_LO = 3'd0;
  localparam logic [2:0] OFS_SCROLL_HI = 3'd1;
  localparam logic [2:0] OFS_FLIP      = 3'd2;
  localparam logic [2:0] OFS_SND_CMD   = 3'd3;
  localparam logic [2:0] OFS_NMI_CLR   = 3'd4;
  localparam logic [2:0] OFS_REPLY     = 3'd5;
  localparam logic [2:0] OFS_SND_STAT  = 3'd6;

  // read-side aliases of offsets shared with writes
  localparam logic [2:0] OFS_P1        = 3'd0;
  localparam logic [2:0] OFS_P2        = 3'd1;
  localparam logic [2:0] OFS_DSW1      = 3'd2;
  localparam logic [2:0] OFS_DSW2      = 3'd3;
  localparam logic [2:0] OFS_SYS_STAT  = 3'd4;

  localparam int VBL_BIT  = 7;
  localparam int OVR_BIT  = 6;
  localparam int FULL_BIT = 7;
  localparam int IRQ_BIT  = 6;

endpackage

// File: rtl/mio_rising_edge.sv
// Single-cycle rising-edge detector; history is seeded from the live input
// during reset so leaving reset never produces a spurious edge.
module mio_rising_edge (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk_sys) begin
    din_q <= din;
  end

  assign rise = din & ~din_q & reset_n;

endmodule

// File: rtl/mio.sv
// CPU-facing I/O window: player/DIP inputs, scroll/flip control and a
// handshaked command/reply mailbox to the sound CPU.
module mio
  import mio_pkg::*;
#(
  parameter logic [15:0] BASE = 16'h2800
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        cen,
  input  logic [15:0] cpu_ab,
  input  logic [7:0]  cpu_dout,
  input  logic        rw,
  output logic        io_sel,
  output logic [7:0]  io_dout,
  input  logic [7:0]  p1,
  input  logic [7:0]  p2,
  input  logic [7:0]  dsw1,
  input  logic [7:0]  dsw2,
  input  logic [5:0]  sys_in,
  input  logic        vblk,
  output logic [8:0]  scroll_x,
  output logic        flip,
  output logic        nmi_clear,
  output logic [7:0]  snd_cmd,
  output logic        snd_irq,
  input  logic        snd_ack,
  input  logic        snd_reply_we,
  input  logic [7:0]  snd_reply_din
);

  logic [2:0] ofs;
  logic       commit_wr;
  logic       commit_rd;
  logic       vblk_rise;
  logic       vbl_flag;
  logic       ovr_flag;
  logic       reply_full;
  logic [7:0] reply_q;
  logic [7:0] sys_stat;
  logic [7:0] snd_stat;
  logic       wr_cmd;

  assign io_sel    = (cpu_ab[15:3] == BASE[15:3]);
  assign ofs       = cpu_ab[2:0];
  assign commit_wr = cen & io_sel & ~rw;
  assign commit_rd = cen & io_sel & rw;
  assign wr_cmd    = commit_wr && (ofs == OFS_SND_CMD);

  mio_rising_edge u_vblk_edge (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .din     (vblk),
    .rise    (vblk_rise)
  );

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      scroll_x   <= 9'd0;
      flip       <= 1'b0;
      snd_cmd    <= 8'd0;
      snd_irq    <= 1'b0;
      nmi_clear  <= 1'b0;
      vbl_flag   <= 1'b0;
      ovr_flag   <= 1'b0;
      reply_q    <= 8'd0;
      reply_full <= 1'b0;
    end else begin
      nmi_clear <= commit_wr && (ofs == OFS_NMI_CLR);

      if (commit_wr) begin
        case (ofs)
          OFS_SCROLL_LO: scroll_x[7:0] <= cpu_dout;
          OFS_SCROLL_HI: scroll_x[8]   <= cpu_dout[0];
          OFS_FLIP:      flip          <= cpu_dout[0];
          OFS_SND_CMD:   snd_cmd       <= cpu_dout;
          default: ;
        endcase
      end

      // a new command outranks a simultaneous acknowledge
      if (wr_cmd)
        snd_irq <= 1'b1;
      else if (snd_ack)
        snd_irq <= 1'b0;

      if (wr_cmd && snd_irq)
        ovr_flag <= 1'b1;
      else if (commit_rd && (ofs == OFS_SYS_STAT))
        ovr_flag <= 1'b0;

      if (vblk_rise)
        vbl_flag <= 1'b1;
      else if (commit_rd && (ofs == OFS_SYS_STAT))
        vbl_flag <= 1'b0;

      if (snd_reply_we) begin
        reply_q    <= snd_reply_din;
        reply_full <= 1'b1;
      end else if (commit_rd && (ofs == OFS_REPLY)) begin
        reply_full <= 1'b0;
      end
    end
  end

  always_comb begin
    sys_stat           = {2'b00, sys_in};
    sys_stat[VBL_BIT]  = vbl_flag;
    sys_stat[OVR_BIT]  = ovr_flag;
    snd_stat           = 8'h00;
    snd_stat[FULL_BIT] = reply_full;
    snd_stat[IRQ_BIT]  = snd_irq;
  end

  always_comb begin
    io_dout = 8'hFF;
    if (io_sel) begin
      case (ofs)
        OFS_P1:       io_dout = p1;
        OFS_P2:       io_dout = p2;
        OFS_DSW1:     io_dout = dsw1;
        OFS_DSW2:     io_dout = dsw2;
        OFS_SYS_STAT: io_dout = sys_stat;
        OFS_REPLY:    io_dout = reply_q;
        OFS_SND_STAT: io_dout = snd_stat;
        default:      io_dout = 8'hFF;
      endcase
    end
  end

endmodule

// File: tb/tb_mio.sv
// Randomized scoreboard bench for mio against a behavioural register-map model.
module tb_mio;

  localparam logic [15:0] BASE = 16'h2800;

  typedef struct packed {
    logic [8:0] scroll;
    logic       flip;
    logic [7:0] cmd;
    logic       irq;
    logic       nmi;
    logic       vbl;
    logic       ovr;
    logic [7:0] rep;
    logic       full;
  } st_t;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        cen = 1'b0;
  logic [15:0] cpu_ab = 16'h0000;
  logic [7:0]  cpu_dout = 8'h00;
  logic        rw = 1'b1;
  logic        io_sel;
  logic [7:0]  io_dout;
  logic [7:0]  p1 = 8'hFF, p2 = 8'hFF, dsw1 = 8'hFF, dsw2 = 8'hFF;
  logic [5:0]  sys_in = 6'h3F;
  logic        vblk = 1'b0;
  logic [8:0]  scroll_x;
  logic        flip, nmi_clear, snd_irq;
  logic [7:0]  snd_cmd;
  logic        snd_ack = 1'b0;
  logic        snd_reply_we = 1'b0;
  logic [7:0]  snd_reply_din = 8'h00;

  int checks = 0;
  int errors = 0;

  st_t        m = '0;
  logic       m_prev = 1'b0;
  logic       vb_lvl = 1'b0;
  st_t        st_q[$];
  logic [8:0] rd_q[$];

  mio #(.BASE(BASE)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .cen(cen), .cpu_ab(cpu_ab),
    .cpu_dout(cpu_dout), .rw(rw), .io_sel(io_sel), .io_dout(io_dout),
    .p1(p1), .p2(p2), .dsw1(dsw1), .dsw2(dsw2), .sys_in(sys_in),
    .vblk(vblk), .scroll_x(scroll_x), .flip(flip), .nmi_clear(nmi_clear),
    .snd_cmd(snd_cmd), .snd_irq(snd_irq), .snd_ack(snd_ack),
    .snd_reply_we(snd_reply_we), .snd_reply_din(snd_reply_din)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] read_val(input logic [2:0] o);
    case (o)
      3'd0:    return p1;
      3'd1:    return p2;
      3'd2:    return dsw1;
      3'd3:    return dsw2;
      3'd4:    return {m.vbl, m.ovr, sys_in};
      3'd5:    return m.rep;
      3'd6:    return {m.full, m.irq, 6'b0};
      default: return 8'hFF;
    endcase
  endfunction

  // drives one bus cycle (called at a falling edge), predicts, returns at next falling edge
  task automatic cyc(input logic rst_n_i, input logic c, input logic [15:0] a, input logic r,
                     input logic [7:0] d, input logic ack, input logic rwe,
                     input logic [7:0] rdin, input logic vb);
    st_t        nx;
    logic       sel, rise, wr_hit, rd_hit;
    logic [2:0] o;
    reset_n = rst_n_i; cen = c; cpu_ab = a; rw = r; cpu_dout = d;
    snd_ack = ack; snd_reply_we = rwe; snd_reply_din = rdin; vblk = vb;
    p1 = 8'($urandom); p2 = 8'($urandom); dsw1 = 8'($urandom); dsw2 = 8'($urandom);
    sys_in = 6'($urandom);
    sel    = (a[15:3] == BASE[15:3]);
    o      = a[2:0];
    wr_hit = c && sel && !r;
    rd_hit = c && sel && r;
    if (c && r) rd_q.push_back({sel, sel ? read_val(o) : 8'hFF});
    rise = vb && !m_prev;
    if (!rst_n_i) begin
      nx = '0;
    end else begin
      nx = m;
      nx.nmi = 1'b0;
      if (ack) nx.irq = 1'b0;
      if (wr_hit) begin
        case (o)
          3'd0: nx.scroll[7:0] = d;
          3'd1: nx.scroll[8] = d[0];
          3'd2: nx.flip = d[0];
          3'd3: begin nx.ovr = nx.ovr | m.irq; nx.cmd = d; nx.irq = 1'b1; end
          3'd4: nx.nmi = 1'b1;
          default: ;
        endcase
      end
      if (rd_hit && o == 3'd4) begin nx.vbl = 1'b0; nx.ovr = 1'b0; end
      if (rd_hit && o == 3'd5) nx.full = 1'b0;
      if (rise) nx.vbl = 1'b1;
      if (rwe) begin nx.rep = rdin; nx.full = 1'b1; end
    end
    m_prev = vb;
    m = nx;
    st_q.push_back(nx);
    @(negedge clk_sys);
  endtask

  task automatic wr(input logic [2:0] o, input logic [7:0] d);
    cyc(1'b1, 1'b1, BASE + 16'(o), 1'b0, d, 1'b0, 1'b0, 8'h00, vb_lvl);
  endtask

  task automatic rd(input logic [2:0] o);
    cyc(1'b1, 1'b1, BASE + 16'(o), 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, vb_lvl);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, BASE, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, vb_lvl);
  endtask

  // state monitor: one expected snapshot per clock edge
  initial begin
    st_t e;
    forever begin
      @(posedge clk_sys);
      #1;
      if (st_q.size() != 0) begin
        e = st_q.pop_front();
        chk("scroll_x",  16'(scroll_x),  16'(e.scroll));
        chk("flip",      16'(flip),      16'(e.flip));
        chk("snd_cmd",   16'(snd_cmd),   16'(e.cmd));
        chk("snd_irq",   16'(snd_irq),   16'(e.irq));
        chk("nmi_clear", 16'(nmi_clear), 16'(e.nmi));
      end
    end
  end

  // read monitor: compares whenever the CPU presents a read strobe
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk_sys);
      #2;
      if (cen && rw) begin
        if (rd_q.size() == 0) begin
          chk("rd_q_underflow", 16'(rd_q.size()), 16'd1);
        end else begin
          e = rd_q.pop_front();
          chk("io_sel",  16'(io_sel),  16'(e[8]));
          chk("io_dout", 16'(io_dout), 16'(e[7:0]));
        end
      end
    end
  end

  initial begin
    logic [15:0] ra;
    @(negedge clk_sys);
    repeat (3) cyc(1'b0, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, vb_lvl);
    chk("rst_scroll", 16'(scroll_x), 16'h0);
    chk("rst_irq", 16'(snd_irq), 16'h0);

    wr(3'd0, 8'h34);
    chk("scroll_lo", 16'(scroll_x), 16'h034);
    wr(3'd1, 8'h01);
    chk("scroll_full", 16'(scroll_x), 16'h134);
    wr(3'd2, 8'h01);
    chk("flip_set", 16'(flip), 16'h1);

    wr(3'd3, 8'h5A);
    chk("cmd_5a", 16'(snd_cmd), 16'h5A);
    chk("irq_set", 16'(snd_irq), 16'h1);
    wr(3'd3, 8'hA5);
    chk("cmd_a5", 16'(snd_cmd), 16'hA5);
    rd(3'd4);
    rd(3'd4);
    rd(3'd6);

    cyc(1'b1, 1'b1, BASE + 16'd3, 1'b0, 8'h11, 1'b1, 1'b0, 8'h00, vb_lvl);
    chk("ack_wr_irq", 16'(snd_irq), 16'h1);
    chk("ack_wr_cmd", 16'(snd_cmd), 16'h11);
    cyc(1'b1, 1'b0, BASE, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, vb_lvl);
    chk("ack_clr", 16'(snd_irq), 16'h0);
    wr(3'd3, 8'h22);
    rd(3'd4);

    vb_lvl = 1'b1;
    rd(3'd4);
    rd(3'd4);
    rd(3'd4);
    vb_lvl = 1'b0;
    idle();

    wr(3'd4, 8'hAA);
    chk("nmi_pulse", 16'(nmi_clear), 16'h1);
    idle();
    chk("nmi_drop", 16'(nmi_clear), 16'h0);
    cyc(1'b1, 1'b0, BASE + 16'd4, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, vb_lvl);
    chk("nmi_nocen", 16'(nmi_clear), 16'h0);

    cyc(1'b1, 1'b0, BASE, 1'b1, 8'h00, 1'b0, 1'b1, 8'hC3, vb_lvl);
    rd(3'd6);
    rd(3'd5);
    rd(3'd6);
    cyc(1'b1, 1'b1, BASE + 16'd5, 1'b1, 8'h00, 1'b0, 1'b1, 8'h3C, vb_lvl);
    rd(3'd6);
    rd(3'd7);
    cyc(1'b1, 1'b1, 16'h1234, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, vb_lvl);

    wr(3'd3, 8'h77);
    wr(3'd4, 8'h00);
    cyc(1'b0, 1'b1, BASE + 16'd3, 1'b0, 8'h99, 1'b0, 1'b1, 8'h55, vb_lvl);
    chk("rst_mid_nmi", 16'(nmi_clear), 16'h0);
    chk("rst_mid_cmd", 16'(snd_cmd), 16'h0);
    chk("rst_mid_scroll", 16'(scroll_x), 16'h0);
    rd(3'd6);
    rd(3'd4);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) ra = 16'($urandom);
      else ra = BASE + 16'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) vb_lvl = ~vb_lvl;
      cyc($urandom_range(0, 99) != 0, 1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)),
          8'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
          8'($urandom), vb_lvl);
    end

    idle();
    idle();
    chk("sb_drain", 16'(st_q.size() + rd_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mio.md
MIO -- requirements
Module: mio

Interface
REQ-001 SHALL have parameter BASE, default 16'h2800, giving the I/O window base; the window spans BASE..BASE+7.
REQ-002 SHALL have port clk_sys  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports cen (input, 1, CPU bus-cycle strobe, one clk_sys wide) and cpu_ab (input, 16, CPU address).
REQ-005 SHALL have ports cpu_dout (input, 8, CPU write data) and rw (input, 1, 1=read, 0=write).
REQ-006 SHALL have ports io_sel (output, 1, address in window) and io_dout (output, 8, read data to the CPU).
REQ-007 SHALL have ports p1, p2, dsw1, dsw2 (input, 8 each, active-low player and DIP inputs) and sys_in (input, 6, coin/start).
REQ-008 SHALL have port vblk  input  1  vertical blank level.
REQ-009 SHALL have ports scroll_x (output, 9), flip (output, 1) and nmi_clear (output, 1, one-clk pulse).
REQ-010 SHALL have ports snd_cmd (output, 8), snd_irq (output, 1) and snd_ack (input, 1, one-clk pulse from the sound CPU).
REQ-011 SHALL have ports snd_reply_we (input, 1) and snd_reply_din (input, 8), the sound CPU reply write.

Function
REQ-012 SHALL drive io_sel combinationally when cpu_ab[15:3]==BASE[15:3].
REQ-013 SHALL commit bus accesses only on a clk_sys edge with cen=1 and io_sel=1; write-side effects SHALL appear on the following cycle.
REQ-014 SHALL map writes as: +0 scroll_x[7:0]; +1 scroll_x[8]=d[0]; +2 flip=d[0]; +3 snd_cmd=d and set snd_irq; +4 pulse nmi_clear for exactly 1 clk_sys, data ignored; +5..+7 ignored.
REQ-015 SHALL map reads combinationally as: +0 p1; +1 p2; +2 dsw1; +3 dsw2; +4 {vbl_flag, ovr_flag, sys_in}; +5 reply latch; +6 {reply_full, snd_irq, 6'b0}; +7 8'hFF.
REQ-016 SHALL set vbl_flag on a rising edge of vblk and clear it on a committed read of +4; on a simultaneous set and clear, set SHALL win.
REQ-017 SHALL clear snd_irq on snd_ack; when snd_ack coincides with a committed +3 write, snd_irq SHALL stay 1 and snd_cmd SHALL take the new value.
REQ-018 SHALL set the sticky ovr_flag on a committed +3 write while snd_irq=1 (the command is still overwritten); ovr_flag SHALL clear only on a committed read of +4.
REQ-019 SHALL load the reply latch and set reply_full on snd_reply_we; a committed +5 read SHALL clear reply_full, and on coincidence set SHALL win.
REQ-020 SHALL give reads of +0..+3, +6 and +7 no side effects; reads with cen=0 SHALL have no side effects.
REQ-021 SHALL output io_dout=8'hFF when io_sel=0.

Reset
REQ-022 SHALL, while reset_n=0, reset scroll_x=0, flip=0, snd_cmd=0, snd_irq=0, nmi_clear=0, vbl_flag=0, ovr_flag=0, reply latch=0, reply_full=0, and the vblk edge history to the current vblk.
REQ-023 SHALL let reset_n override every access and pulse in the same cycle, including a nmi_clear pulse in progress, which SHALL drop.

Structure
REQ-024 SHALL place register offsets (+0..+7) and status bit positions in the shared package mio_pkg.
REQ-025 SHALL detect vblk edges with the codebase's rising_edge sub-module; no other sub-module.

Verification
REQ-026 SHALL test: write 8'h34 to BASE+0, then 8'h01 to BASE+1 -> scroll_x=9'h134 one cycle after each cen.
REQ-027 SHALL test: write 8'h5A to BASE+3 -> snd_cmd=8'h5A, snd_irq=1; then write 8'hA5 to BASE+3 before snd_ack -> snd_cmd=8'hA5, +4 read bit6=1, and the next +4 read bit6=0.
REQ-028 SHALL test: snd_ack coincident with a write of 8'h11 to BASE+3 -> snd_irq stays 1 and snd_cmd=8'h11.
REQ-029 SHALL test: a vblk rise coincident with a committed +4 read -> vbl_flag=1 afterwards; a second +4 read returns bit7=1 and then vbl_flag=0.
REQ-030 SHALL test: a write to BASE+4 -> nmi_clear high for exactly one clk_sys; the same write with cen=0 -> no pulse.
REQ-031 SHALL test: snd_reply_we with 8'hC3, then read BASE+5 -> 8'hC3, reply_full 1 then 0; reset_n=0 mid-sequence -> all outputs at their reset values next cycle.
